mem_port_sequencer: RTL and testbench
=====================================

// Module: mem_port_sequencer
// PURPOSE
//  Shares one byte-wide single-port synchronous RAM (512x8) between the instruction-fetch port (I) and the data port (D).
//  Serialises byte/halfword/word requests into per-byte RAM cycles and assembles read data big-endian.
//  Sign-extends D reads, and returns data with a one-cycle Ack pulse. Sits between the MIPS core's fetch/MEM stages and the memory array.
// PARAMETERS
//  ADDR_W   9   byte-address width; RAM depth = 2**ADDR_W
//  DATA_W   32  requester data width (fixed: 4 bytes)
// PORTS
//  Clk         in   1   sole clock, rising edge
//  Reset       in   1   synchronous, active-low reset
//  IReq        in   1   fetch request (word read only)
//  IAddr       in   9   fetch byte address
//  IAck        out  1   one-cycle pulse: IData valid
//  IData       out  32  fetched word, big-endian
//  IErr        out  1   alignment fault, valid with IAck
//  DReq        in   1   data request
//  DReadWrite  in   1   1 = write, 0 = read
//  DSize       in   2   00 byte, 01 half, 10 word, 11 treated as word
//  DSignExtend in   1   reads only: sign-extend byte/half
//  DAddr       in   9   data byte address
//  DWData      in   32  store data; byte uses [7:0], half uses [15:0]
//  DAck        out  1   one-cycle pulse: access done / DData valid
//  DData       out  32  load result
//  DErr        out  1   alignment fault, valid with DAck
//  Busy        out  1   FSM not in IDLE
//  MemAddr     out  9   RAM byte address
//  MemWe       out  1   RAM write strobe for this cycle
//  MemWData    out  8   RAM write byte
//  MemRData    in   8   RAM read byte, valid 1 cycle after MemAddr
// BEHAVIOUR
//  - Reset (Reset==0 at edge): state=IDLE, all outputs 0, LastGrant=I, counters 0. Aborts any transfer mid-flight; no Ack is issued for it.
//  - Handshake: requester holds Req and fields until Ack. Fields are latched at grant.
//    If Req drops after grant, the access still completes and Ack still pulses.
//  - Arbitration in IDLE only. With a single requester, grant it. If both request, grant the one not equal to LastGrant (round-robin).
//    LastGrant updates on every grant.
//  - States: IDLE -> XFER (N cycles, N=1/2/4 bytes) -> DRAIN (reads only, 1 cycle) -> DONE (1 cycle, Ack=1) -> IDLE.
//  - XFER cycle k: MemAddr=Base+k (mod 512, wraps 511->0). For writes, MemWe=1 and MemWData=byte k (MSB first). For reads, MemWe=0.
//    Reads capture MemRData into byte k-1 when k>0; DRAIN captures byte N-1.
//  - Latency, Req sampled in IDLE at cycle 0: write Ack at cycle N+1; read Ack at cycle N+2. Word read = 6 cycles.
//  - DData: byte -> {ext24,b0}; half -> {ext16,b0,b1}; ext = bit7 of b0 if DSignExtend, else 0. Word -> {b0,b1,b2,b3}.
//  - Write Ack: DData holds its previous value. IData/DData keep their value until the next Ack on that port.
//  - Only one port Acks per cycle. DONE returns to IDLE; a request pending at that time is arbitrated in the IDLE cycle.
//  - MemWe=0 in every state except write XFER.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: misaligned accesses are faulted. Misaligned means half with Addr[0]!=0, or word with Addr[1:0]!=0.
//    On a fault: IDLE -> DONE directly, no RAM cycle, MemWe stays 0, Ack=1 with Err=1, data regs unchanged.
//  Undefined: no check. Misaligned accesses proceed byte-serially with wrap. IErr/DErr are tied to 0.
// STRUCTURE
//  Shared package mem_ctrl_pkg: SZ_BYTE/SZ_HALF/SZ_WORD encodings, state encoding (IDLE, XFER, DRAIN, DONE), GRANT_I/GRANT_D.
//  Sub-module mem_rr_arbiter: 2-way round-robin (IReq, DReq, LastGrant -> GntI, GntD).
//  Remaining FSM, byte counter, assembly and extension stay in this module.
// TESTING
//  - D word write 0xDEADBEEF @0x010, then D word read @0x010: MemWe on 4 cycles, bytes DE,AD,BE,EF to 0x010..0x013.
//    DAck at +5 for the write; for the read, DAck at +6 with DData=0xDEADBEEF.
//  - Byte 0x80 @0x020, read size 00 with SignExtend=1 -> 0xFFFFFF80; with SignExtend=0 -> 0x00000080.
//    Half 0x8001 read, sign-ext -> 0xFFFF8001.
//  - IReq and DReq asserted in the same cycle after reset: D served first, then I.
//    Both held continuously: grants alternate D,I,D,I, never two Acks in one cycle.
//  - Word write @0x1FE: bytes land at 0x1FE,0x1FF,0x000,0x001 (no check); with MEM_ALIGN_CHECK_EN, DErr=1 at +1 and no MemWe.
//  - Reset driven low during XFER of a word read: next cycle all outputs 0 and state IDLE.
//    No DAck is ever produced for that request; a fresh request then completes normally.
//  - DReq dropped one cycle after grant on a half write: 2 bytes still written, DAck pulses once at +3.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings and helpers for the memory port sequencer
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // Index of the final byte cycle; size 11 is handled as a word.
    function automatic logic [1:0] last_index(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 2'd0;
            SZ_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Halves need an even address, words a 4-byte boundary.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lsb[0];
            default: return lsb != 2'b00;
        endcase
    endfunction

    // Left-justify store data so the byte to send first is always [31:24].
    function automatic logic [31:0] align_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {wdata[7:0], 24'h000000};
            SZ_HALF: return {wdata[15:0], 16'h0000};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-way round-robin grant between fetch and data ports
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic   ireq,
    input  logic   dreq,
    input  grant_t last_grant,
    output logic   gnt_i,
    output logic   gnt_d
);

    // A lone requester always wins; on a tie the port not served last wins.
    always_comb begin
        gnt_i = ireq & (~dreq | (last_grant == GRANT_D));
        gnt_d = dreq & (~ireq | (last_grant == GRANT_I));
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// rtl/mem_port_sequencer.sv - shares a byte-wide RAM between fetch and data ports; MEM_ALIGN_CHECK_EN enables alignment faults
module mem_port_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IAck,
    output logic [DATA_W-1:0] IData,
    output logic              IErr,
    input  logic              DReq,
    input  logic              DReadWrite,
    input  logic [1:0]        DSize,
    input  logic              DSignExtend,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DAck,
    output logic [DATA_W-1:0] DData,
    output logic              DErr,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [7:0]        MemWData,
    input  logic [7:0]        MemRData
);

    state_t              state;
    state_t              next_state;
    grant_t              last_grant;
    grant_t              cur_port;
    logic                cur_we;
    logic                cur_sext;
    logic [1:0]          cur_size;
    logic [1:0]          cnt;
    logic [ADDR_W-1:0]   base;
    logic [DATA_W-1:0]   wbuf;
    logic [23:0]         rbuf;

    logic                gnt_i;
    logic                gnt_d;
    logic                grant;
    logic                mis;
    logic [1:0]          sel_size;
    logic [ADDR_W-1:0]   sel_addr;
    logic                xfer_last;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   rd_result;

    mem_rr_arbiter u_arb (
        .ireq       (IReq),
        .dreq       (DReq),
        .last_grant (last_grant),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    assign grant     = gnt_i | gnt_d;
    assign sel_size  = gnt_d ? DSize : SZ_WORD;
    assign sel_addr  = gnt_d ? DAddr : IAddr;
    assign xfer_last = (cnt == last_index(cur_size));

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = grant & misaligned(sel_size, sel_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    // Next-state: faulted grants skip the RAM entirely; writes need no drain cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    next_state = mis ? DONE : XFER;
                end
            end
            XFER: begin
                if (xfer_last) begin
                    next_state = cur_we ? DONE : DRAIN;
                end
            end
            DRAIN:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch request fields at grant, step the byte counter and shift in read bytes.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_grant <= GRANT_I;
            cur_port   <= GRANT_I;
            cur_we     <= 1'b0;
            cur_sext   <= 1'b0;
            cur_size   <= SZ_BYTE;
            cnt        <= 2'd0;
            base       <= '0;
            wbuf       <= '0;
            rbuf       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cur_port   <= gnt_d ? GRANT_D : GRANT_I;
                        last_grant <= gnt_d ? GRANT_D : GRANT_I;
                        cur_we     <= gnt_d & DReadWrite;
                        cur_sext   <= gnt_d & DSignExtend;
                        cur_size   <= sel_size;
                        base       <= sel_addr;
                        wbuf       <= gnt_d ? align_wdata(DSize, DWData) : '0;
                        cnt        <= 2'd0;
                    end
                end
                XFER: begin
                    cnt <= cnt + 2'd1;
                    // RAM data lags the address by one cycle, so byte k-1 arrives in cycle k.
                    if (!cur_we && (cnt != 2'd0)) begin
                        rbuf <= {rbuf[15:0], MemRData};
                    end
                end
                default: ;
            endcase
        end
    end

    assign rd_word = {rbuf, MemRData};

    // Assemble the load result; byte 0 was fetched first and is the most significant.
    always_comb begin
        rd_result = rd_word;
        case (cur_size)
            SZ_BYTE: rd_result = {{24{cur_sext & rd_word[7]}}, rd_word[7:0]};
            SZ_HALF: rd_result = {{16{cur_sext & rd_word[15]}}, rd_word[15:0]};
            default: rd_result = rd_word;
        endcase
    end

    // Return registers load only at the end of a read drain and otherwise hold.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            IData <= '0;
            DData <= '0;
        end else if (state == DRAIN) begin
            if (cur_port == GRANT_I) begin
                IData <= rd_word;
            end else begin
                DData <= rd_result;
            end
        end
    end

    // Pick the outgoing write byte, MSB first.
    always_comb begin
        MemWData = 8'h00;
        if (MemWe) begin
            case (cnt)
                2'd0:    MemWData = wbuf[31:24];
                2'd1:    MemWData = wbuf[23:16];
                2'd2:    MemWData = wbuf[15:8];
                default: MemWData = wbuf[7:0];
            endcase
        end
    end

    assign Busy    = (state != IDLE);
    assign IAck    = (state == DONE) && (cur_port == GRANT_I);
    assign DAck    = (state == DONE) && (cur_port == GRANT_D);
    assign MemWe   = (state == XFER) && cur_we;
    assign MemAddr = (state == XFER) ? (base + ADDR_W'(cnt)) : '0;

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    // Fault flag is decided at grant and reported alongside the Ack.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            err_q <= 1'b0;
        end else if ((state == IDLE) && grant) begin
            err_q <= mis;
        end
    end

    assign IErr = IAck & err_q;
    assign DErr = DAck & err_q;
`else
    assign IErr = 1'b0;
    assign DErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb/tb_mem_port_sequencer.sv - self-checking bench for mem_port_sequencer
module tb_mem_port_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        IReq = 1'b0;
    logic [8:0]  IAddr = '0;
    logic        IAck;
    logic [31:0] IData;
    logic        IErr;
    logic        DReq = 1'b0;
    logic        DReadWrite = 1'b0;
    logic [1:0]  DSize = '0;
    logic        DSignExtend = 1'b0;
    logic [8:0]  DAddr = '0;
    logic [31:0] DWData = '0;
    logic        DAck;
    logic [31:0] DData;
    logic        DErr;
    logic        Busy;
    logic [8:0]  MemAddr;
    logic        MemWe;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData = '0;

    int errors = 0;
    int checks = 0;
    int d_acks = 0;
    int i_acks = 0;
    int dual = 0;
    int we_cycles = 0;
    int exp_dacks = 0;
    int exp_iacks = 0;
    logic [31:0] exp_ddata = '0;
    logic [31:0] exp_idata = '0;

    logic [7:0] ram [512];
    logic [7:0] ref_mem [512];
    bit ram_load = 1'b1;

    always #5 Clk = ~Clk;

    mem_port_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .IReq        (IReq),
        .IAddr       (IAddr),
        .IAck        (IAck),
        .IData       (IData),
        .IErr        (IErr),
        .DReq        (DReq),
        .DReadWrite  (DReadWrite),
        .DSize       (DSize),
        .DSignExtend (DSignExtend),
        .DAddr       (DAddr),
        .DWData      (DWData),
        .DAck        (DAck),
        .DData       (DData),
        .DErr        (DErr),
        .Busy        (Busy),
        .MemAddr     (MemAddr),
        .MemWe       (MemWe),
        .MemWData    (MemWData),
        .MemRData    (MemRData)
    );

    // Synchronous single-port RAM with one-cycle read latency.
    always @(posedge Clk) begin
        if (ram_load) begin
            for (int i = 0; i < 512; i++) ram[i] <= 8'(i * 37 + 5);
        end else if (MemWe) begin
            ram[MemAddr] <= MemWData;
        end
        MemRData <= ram[MemAddr];
    end

    always @(negedge Clk) begin
        if (DAck) d_acks++;
        if (IAck) i_acks++;
        if (DAck && IAck) dual++;
        if (MemWe) we_cycles++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [8:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return ((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'd0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_read(input logic [8:0] a, input int nb, input bit sx);
        logic [31:0] v = 0;
        for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[(a + k) % 512]);
        if (sx && nb < 4 && v[8 * nb - 1]) v = v | ~((32'h1 << (8 * nb)) - 1);
        return v;
    endfunction

    task automatic wait_idle();
        int g = 0;
        while (Busy && g < 20) begin
            @(posedge Clk); #1;
            g++;
        end
    endtask

    task automatic d_access(input bit we, input logic [1:0] sz, input bit sx,
                            input logic [8:0] a, input logic [31:0] wd, input bit drop_early);
        int n, nb, lat, we0;
        bit m;
        wait_idle();
        nb = nbytes(sz);
        m = is_mis(sz, a);
        if (m) begin
            lat = 1;
        end else if (we) begin
            lat = nb + 1;
            for (int k = 0; k < nb; k++) ref_mem[(a + k) % 512] = 8'((wd >> (8 * (nb - 1 - k))) & 32'hFF);
        end else begin
            lat = nb + 2;
            exp_ddata = ref_read(a, nb, sx);
        end
        exp_dacks++;
        we0 = we_cycles;
        DReq = 1'b1; DReadWrite = we; DSize = sz; DSignExtend = sx; DAddr = a; DWData = wd;
        n = 0;
        while (n < 20) begin
            @(posedge Clk); #1;
            n++;
            if (drop_early && n == 1) DReq = 1'b0;
            if (DAck) break;
        end
        DReq = 1'b0;
        check_eq("d_latency", n, lat);
        check_eq("d_data", DData, exp_ddata);
        check_eq("d_err", 32'(DErr), 32'(m));
        check_eq("d_we_cycles", we_cycles - we0, (we && !m) ? nb : 0);
    endtask

    task automatic i_fetch(input logic [8:0] a);
        int n, lat;
        bit m;
        wait_idle();
        m = is_mis(2'd2, a);
        lat = m ? 1 : 6;
        if (!m) exp_idata = ref_read(a, 4, 1'b0);
        exp_iacks++;
        IReq = 1'b1; IAddr = a;
        n = 0;
        while (n < 20) begin
            @(posedge Clk); #1;
            n++;
            if (IAck) break;
        end
        IReq = 1'b0;
        check_eq("i_latency", n, lat);
        check_eq("i_data", IData, exp_idata);
        check_eq("i_err", 32'(IErr), 32'(m));
    endtask

    initial begin
        int n, got, first_n, bad;
        int ord [4];
        logic [31:0] expd, expi;

        for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge Clk);
        ram_load = 1'b0;
        #1;
        check_eq("reset_ctrl", {22'd0, Busy, MemWe, MemAddr, MemWData[5:0]} | {30'd0, IAck, DAck}, 32'd0);
        check_eq("reset_wdata_err", {22'd0, MemWData, IErr, DErr}, 32'd0);
        check_eq("reset_idata", IData, 32'd0);
        check_eq("reset_ddata", DData, 32'd0);
        Reset = 1'b1;
        @(posedge Clk); #1;

        // Simultaneous requests straight after reset, then held: D,I,D,I.
        expd = ref_read(9'h010, 4, 1'b0);
        expi = ref_read(9'h100, 4, 1'b0);
        DReq = 1'b1; DReadWrite = 1'b0; DSize = 2'd2; DSignExtend = 1'b0; DAddr = 9'h010;
        IReq = 1'b1; IAddr = 9'h100;
        n = 0; got = 0; first_n = 0;
        for (int k = 0; k < 4; k++) ord[k] = -1;
        while (got < 4 && n < 60) begin
            @(posedge Clk); #1;
            n++;
            if (DAck) begin
                check_eq("dual_ddata", DData, expd);
                if (got == 0) first_n = n;
                ord[got] = 1; got++;
            end else if (IAck) begin
                check_eq("dual_idata", IData, expi);
                if (got == 0) first_n = n;
                ord[got] = 0; got++;
            end
        end
        DReq = 1'b0; IReq = 1'b0;
        exp_dacks += 2; exp_iacks += 2;
        exp_ddata = expd; exp_idata = expi;
        check_eq("dual_count", got, 4);
        check_eq("dual_first_latency", first_n, 6);
        for (int k = 0; k < 4; k++) check_eq("dual_order", ord[k], (k % 2 == 0) ? 1 : 0);

        // Directed cases.
        d_access(1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0);
        d_access(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 1'b0);
        check_eq("deadbeef", DData, 32'hDEADBEEF);
        d_access(1'b1, 2'd0, 1'b0, 9'h020, 32'h00000080, 1'b0);
        d_access(1'b0, 2'd0, 1'b1, 9'h020, 32'h0, 1'b0);
        check_eq("byte_sext", DData, 32'hFFFFFF80);
        d_access(1'b0, 2'd0, 1'b0, 9'h020, 32'h0, 1'b0);
        check_eq("byte_zext", DData, 32'h00000080);
        d_access(1'b1, 2'd1, 1'b0, 9'h030, 32'h00008001, 1'b0);
        d_access(1'b0, 2'd1, 1'b1, 9'h030, 32'h0, 1'b0);
        check_eq("half_sext", DData, 32'hFFFF8001);
        d_access(1'b1, 2'd2, 1'b0, 9'h1FE, 32'h11223344, 1'b0);
        wait_idle();
`ifndef MEM_ALIGN_CHECK_EN
        check_eq("wrap_1ff", 32'(ram[9'h1FF]), 32'h22);
        check_eq("wrap_000", 32'(ram[9'h000]), 32'h33);
        check_eq("wrap_001", 32'(ram[9'h001]), 32'h44);
`endif
        d_access(1'b1, 2'd1, 1'b0, 9'h050, 32'h0000A5C3, 1'b1);
        d_access(1'b0, 2'd3, 1'b0, 9'h050, 32'h0, 1'b0);
        i_fetch(9'h010);
        check_eq("ifetch_deadbeef", IData, 32'hDEADBEEF);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [8:0] ra;
            ra = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 4) == 0) i_fetch(ra);
            else d_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          ra, $urandom, 1'($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a word read.
        wait_idle();
        DReq = 1'b1; DReadWrite = 1'b0; DSize = 2'd2; DSignExtend = 1'b0; DAddr = 9'h040;
        repeat (3) begin @(posedge Clk); #1; end
        check_eq("abort_inflight", 32'(Busy), 32'd1);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check_eq("abort_ctrl", {20'd0, Busy, MemWe, MemAddr, IAck, DAck}, 32'd0);
        check_eq("abort_wdata", {24'd0, MemWData}, 32'd0);
        check_eq("abort_ddata", DData, 32'd0);
        check_eq("abort_idata", IData, 32'd0);
        Reset = 1'b1; DReq = 1'b0;
        exp_ddata = 32'd0; exp_idata = 32'd0;
        repeat (8) begin @(posedge Clk); #1; end
        check_eq("abort_no_ack", d_acks, exp_dacks);
        d_access(1'b0, 2'd2, 1'b0, 9'h040, 32'h0, 1'b0);
        i_fetch(9'h014);

        wait_idle();
        repeat (2) begin @(posedge Clk); #1; end
        check_eq("total_dacks", d_acks, exp_dacks);
        check_eq("total_iacks", i_acks, exp_iacks);
        check_eq("dual_acks", dual, 0);
        bad = 0;
        for (int i = 0; i < 512; i++) if (ram[i] !== ref_mem[i]) bad++;
        check_eq("ram_image", bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
